// File: rtl/bydin_mem_arb_pkg.sv
// bydin_mem_arb_pkg: shared bydin SRAM arbiter constants and FSM encoding
package bydin_mem_arb_pkg;
  localparam int SRAM_DEPTH = 131072;
  localparam int AW = $clog2(SRAM_DEPTH);
  localparam int DW = 8;
  localparam int TIMEOUT_DEF = 255;
  typedef enum logic [1:0] {IDLE = 2'b01, WAIT = 2'b10} state_t;
endpackage

// File: rtl/bydin_mem_arb_if.sv
// bydin_mem_arb_if: requester A/B and SRAM signals of the interleaver arbiter
interface bydin_mem_arb_if;
  import bydin_mem_arb_pkg::*;
  logic          a_en;
  logic          a_wr;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_di;
  logic [DW-1:0] a_do;
  logic          a_do_en;
  logic          b_req;
  logic          b_wr;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_di;
  logic          b_ack;
  logic [DW-1:0] b_do;
  logic          b_do_en;
  logic          b_timeout;
  logic          ram_en;
  logic          ram_wr;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_di;
  logic [DW-1:0] ram_do;
  modport slave (
    input  a_en, a_wr, a_addr, a_di, b_req, b_wr, b_addr, b_di, ram_do,
    output a_do, a_do_en, b_ack, b_do, b_do_en, b_timeout, ram_en, ram_wr, ram_addr, ram_di
  );
  modport master (
    output a_en, a_wr, a_addr, a_di, b_req, b_wr, b_addr, b_di, ram_do,
    input  a_do, a_do_en, b_ack, b_do, b_do_en, b_timeout, ram_en, ram_wr, ram_addr, ram_di
  );
endinterface

// File: rtl/bydin_mem_arb_sat_cnt.sv
// bydin_mem_arb_sat_cnt: saturating counter with a one-cycle pulse on reaching MAX
module bydin_mem_arb_sat_cnt #(
  parameter int W   = 8,
  parameter int MAX = 255
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt,
  output logic         o_hit
);
  localparam logic [W-1:0] LAST = W'(MAX - 1);
  localparam logic [W-1:0] TOP  = W'(MAX);
  logic [W-1:0] r_cnt;
  assign o_cnt = r_cnt;
  assign o_hit = i_inc & ~i_clr & (r_cnt == LAST);
  // count increments, holding at MAX so the pulse fires only once
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) r_cnt <= '0;
    else r_cnt <= i_clr ? '0 : (i_inc && r_cnt != TOP) ? r_cnt + 1'b1 : r_cnt;
endmodule

// File: rtl/bydin_mem_arb.sv
// bydin_mem_arb: A-priority arbiter for the single-port interleaver SRAM with B handshake
module bydin_mem_arb
  import bydin_mem_arb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input logic             i_clk,
  input logic             i_reset,
  bydin_mem_arb_if.slave  bus
);
  state_t        r_state, w_next;
  logic          r_hold;
  logic [1:0]    r_tag;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_di;
  logic          w_ga, w_gb, w_hit;
  logic [7:0]    w_cnt;
  assign w_ga = bus.a_en & ~i_reset;
  assign w_gb = bus.b_req & ~bus.a_en & ~r_hold & ~i_reset;
  // next state and SRAM mux; idle cycles keep address/data stable
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE && bus.b_req && bus.a_en && !r_hold) w_next = WAIT;
    if (r_state == WAIT && (w_gb || !bus.b_req)) w_next = IDLE;
    bus.ram_en   = w_ga | w_gb;
    bus.ram_wr   = w_ga ? bus.a_wr : w_gb ? bus.b_wr : 1'b0;
    bus.ram_addr = w_ga ? bus.a_addr : w_gb ? bus.b_addr : r_addr;
    bus.ram_di   = w_ga ? bus.a_di : w_gb ? bus.b_di : r_di;
    bus.b_ack    = w_gb;
    bus.a_do     = bus.ram_do;
    bus.b_do     = bus.ram_do;
    bus.a_do_en  = r_tag[1] & ~r_tag[0];
    bus.b_do_en  = r_tag[1] & r_tag[0];
    bus.b_timeout = w_hit;
  end
  // state, hold-off after ack, read-return tag and last SRAM fields
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      r_state <= IDLE;
      r_hold  <= 1'b0;
      r_tag   <= 2'b00;
      r_addr  <= '0;
      r_di    <= '0;
    end else begin
      r_state <= w_next;
      r_hold  <= w_gb ? 1'b1 : bus.b_req ? r_hold : 1'b0;
      r_tag   <= {bus.ram_en & ~bus.ram_wr, w_gb};
      r_addr  <= bus.ram_addr;
      r_di    <= bus.ram_di;
    end
  bydin_mem_arb_sat_cnt #(.W(8), .MAX(TIMEOUT)) u_wait_cnt (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clr   (r_state == IDLE),
    .i_inc   (r_state == WAIT),
    .o_cnt   (w_cnt),
    .o_hit   (w_hit)
  );
  logic w_unused;
  assign w_unused = ^w_cnt;
endmodule

// File: tb/tb_bydin_mem_arb.sv
// tb_bydin_mem_arb: directed self-checking bench for the bydin SRAM arbiter
module tb_bydin_mem_arb;
  import bydin_mem_arb_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  bydin_mem_arb_if bus();
  bydin_mem_arb #(.TIMEOUT(255)) dut (.i_clk(clk), .i_reset(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end
  task automatic idle_inputs();
    bus.a_en = 0; bus.a_wr = 0; bus.a_addr = '0; bus.a_di = '0;
    bus.b_req = 0; bus.b_wr = 0; bus.b_addr = '0; bus.b_di = '0; bus.ram_do = '0;
  endtask
  task automatic test_reset();
    idle_inputs();
    rst = 1;
    repeat (2) @(negedge clk);
    #1;
    n_chk++; if ({bus.a_do_en, bus.b_do_en, bus.b_ack, bus.b_timeout, bus.ram_en, bus.ram_wr} !== 6'b0) begin n_fail++; $display("FAIL rst_flags got %b required 000000", {bus.a_do_en, bus.b_do_en, bus.b_ack, bus.b_timeout, bus.ram_en, bus.ram_wr}); end
    n_chk++; if (bus.ram_addr !== 17'h0 || bus.ram_di !== 8'h0) begin n_fail++; $display("FAIL rst_bus got addr %h di %h required 0 0", bus.ram_addr, bus.ram_di); end
    @(negedge clk) rst = 0;
  endtask
  task automatic test_a_read();
    @(negedge clk) bus.a_en = 1; bus.a_wr = 0; bus.a_addr = 17'h000F0;
    #1;
    n_chk++; if ({bus.ram_en, bus.ram_wr} !== 2'b10 || bus.ram_addr !== 17'h000F0) begin n_fail++; $display("FAIL a_rd_issue got en/wr %b addr %h required 10 000f0", {bus.ram_en, bus.ram_wr}, bus.ram_addr); end
    @(negedge clk) bus.a_en = 0; bus.ram_do = 8'h5A;
    #1;
    n_chk++; if (bus.a_do_en !== 1'b1 || bus.a_do !== 8'h5A) begin n_fail++; $display("FAIL a_rd_data got en %b do %h required 1 5a", bus.a_do_en, bus.a_do); end
    n_chk++; if (bus.b_do_en !== 1'b0) begin n_fail++; $display("FAIL a_rd_bden got %b required 0", bus.b_do_en); end
  endtask
  task automatic test_b_write();
    @(negedge clk) bus.b_req = 1; bus.b_wr = 1; bus.b_addr = 17'h10000; bus.b_di = 8'hC3;
    #1;
    n_chk++; if ({bus.b_ack, bus.ram_en, bus.ram_wr} !== 3'b111 || bus.ram_addr !== 17'h10000 || bus.ram_di !== 8'hC3) begin n_fail++; $display("FAIL b_wr_issue got ack/en/wr %b addr %h di %h required 111 10000 c3", {bus.b_ack, bus.ram_en, bus.ram_wr}, bus.ram_addr, bus.ram_di); end
    @(negedge clk) bus.b_req = 0;
    #1;
    n_chk++; if ({bus.a_do_en, bus.b_do_en, bus.b_ack, bus.ram_en} !== 4'b0) begin n_fail++; $display("FAIL b_wr_after got %b required 0000", {bus.a_do_en, bus.b_do_en, bus.b_ack, bus.ram_en}); end
    n_chk++; if (bus.ram_addr !== 17'h10000 || bus.ram_di !== 8'hC3) begin n_fail++; $display("FAIL b_wr_hold got addr %h di %h required 10000 c3", bus.ram_addr, bus.ram_di); end
  endtask
  task automatic test_blocked();
    logic [3:0] ack_seen;
    logic [2:0] aen_seen;
    ack_seen = '0; aen_seen = '0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      bus.a_en = (c < 3); bus.a_wr = 0; bus.a_addr = 17'(c + 1);
      bus.b_req = 1; bus.b_wr = 0; bus.b_addr = 17'h00010; bus.ram_do = 8'(8'h20 + c);
      #1;
      ack_seen[c] = bus.b_ack;
      if (c > 0) aen_seen[c-1] = bus.a_do_en;
      if (c == 3) begin
        n_chk++; if (bus.ram_addr !== 17'h00010 || {bus.ram_en, bus.ram_wr} !== 2'b10) begin n_fail++; $display("FAIL blk_issue got addr %h en/wr %b required 00010 10", bus.ram_addr, {bus.ram_en, bus.ram_wr}); end
      end
    end
    n_chk++; if (ack_seen !== 4'b1000) begin n_fail++; $display("FAIL blk_ack got %b required 1000", ack_seen); end
    n_chk++; if (aen_seen !== 3'b111) begin n_fail++; $display("FAIL blk_a_b2b got %b required 111", aen_seen); end
    @(negedge clk) bus.b_req = 0; bus.ram_do = 8'h99;
    #1;
    n_chk++; if (bus.b_do_en !== 1'b1 || bus.a_do_en !== 1'b0 || bus.b_do !== 8'h99) begin n_fail++; $display("FAIL blk_bdata got b_en %b a_en %b do %h required 1 0 99", bus.b_do_en, bus.a_do_en, bus.b_do); end
  endtask
  task automatic test_timeout();
    int pulses, at, acks;
    pulses = 0; at = 0; acks = 0;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      bus.a_en = 1; bus.a_wr = 0; bus.a_addr = 17'(c);
      bus.b_req = 1; bus.b_wr = 0; bus.b_addr = 17'h00055;
      #1;
      if (bus.b_timeout) begin pulses++; at = c; end
      if (bus.b_ack) acks++;
    end
    n_chk++; if (pulses !== 1 || at !== 256) begin n_fail++; $display("FAIL tmo_pulse got %0d pulses at cycle %0d required 1 at 256", pulses, at); end
    n_chk++; if (acks !== 0) begin n_fail++; $display("FAIL tmo_starve got %0d acks required 0", acks); end
    @(negedge clk) bus.a_en = 0;
    #1;
    n_chk++; if (bus.b_ack !== 1'b1 || bus.ram_addr !== 17'h00055 || bus.b_timeout !== 1'b0) begin n_fail++; $display("FAIL tmo_ack got ack %b addr %h tmo %b required 1 00055 0", bus.b_ack, bus.ram_addr, bus.b_timeout); end
    @(negedge clk) bus.b_req = 0;
  endtask
  task automatic test_hold();
    int acks, accs;
    acks = 0; accs = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      bus.a_en = 0; bus.b_req = 1; bus.b_wr = 0; bus.b_addr = 17'h00020; bus.ram_do = 8'h3C;
      #1;
      acks += int'(bus.b_ack); accs += int'(bus.ram_en);
      if (c == 1) begin
        n_chk++; if (bus.b_do_en !== 1'b1 || bus.b_do !== 8'h3C) begin n_fail++; $display("FAIL hold_bdata got en %b do %h required 1 3c", bus.b_do_en, bus.b_do); end
      end
    end
    n_chk++; if (acks !== 1 || accs !== 1) begin n_fail++; $display("FAIL hold_once got %0d acks %0d accesses required 1 1", acks, accs); end
    @(negedge clk) bus.b_req = 0;
    @(negedge clk) bus.b_req = 1; bus.b_wr = 1;
    #1;
    n_chk++; if (bus.b_ack !== 1'b1) begin n_fail++; $display("FAIL hold_rearm got %b required 1", bus.b_ack); end
    @(negedge clk) bus.b_req = 0; bus.b_wr = 0;
  endtask
  task automatic test_reset_inflight();
    @(negedge clk) bus.a_en = 0; bus.b_req = 1; bus.b_wr = 0; bus.b_addr = 17'h00077; bus.ram_do = 8'hE1;
    #1;
    n_chk++; if (bus.b_ack !== 1'b1) begin n_fail++; $display("FAIL rsf_issue got %b required 1", bus.b_ack); end
    #1 rst = 1; bus.b_req = 0;
    #1;
    n_chk++; if ({bus.b_ack, bus.ram_en, bus.ram_wr, bus.b_timeout} !== 4'b0 || bus.ram_addr !== 17'h0 || bus.ram_di !== 8'h0) begin n_fail++; $display("FAIL rsf_outs got %b addr %h di %h required 0000 0 0", {bus.b_ack, bus.ram_en, bus.ram_wr, bus.b_timeout}, bus.ram_addr, bus.ram_di); end
    @(negedge clk) #1;
    n_chk++; if (bus.b_do_en !== 1'b0 || bus.a_do_en !== 1'b0) begin n_fail++; $display("FAIL rsf_doen got b %b a %b required 0 0", bus.b_do_en, bus.a_do_en); end
    rst = 0;
    @(negedge clk) #1;
    n_chk++; if (dut.r_state !== IDLE || bus.b_do_en !== 1'b0) begin n_fail++; $display("FAIL rsf_idle got state %b b_do_en %b required 01 0", dut.r_state, bus.b_do_en); end
  endtask
  initial begin
    test_reset();
    test_a_read();
    test_b_write();
    test_blocked();
    test_timeout();
    test_hold();
    test_reset_inflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
